// File: rtl/pc_predictor_pkg.sv
// Shared constants, BTB entry layout and saturating-counter helper for the
// fetch-stage pc predictor.
package pc_pkg;

    localparam int          PC_ADDRESS_WIDTH = 32;
    localparam int          PC_BTB_ENTRIES   = 16;
    localparam int          PC_IDX_W         = $clog2(PC_BTB_ENTRIES);
    localparam int          PC_TAG_W         = PC_ADDRESS_WIDTH - PC_IDX_W - 2;
    localparam logic [31:0] PC_RESET_VECTOR  = 32'hBFC00000;

    localparam logic [1:0]  CTR_WEAK_NT = 2'b01;
    localparam logic [1:0]  CTR_WEAK_T  = 2'b10;

    // Entry layout for the default geometry; btb_table re-derives the same
    // shape from its own parameters so other geometries stay consistent.
    typedef struct packed {
        logic                        valid;
        logic [PC_TAG_W-1:0]         tag;
        logic [PC_ADDRESS_WIDTH-1:0] target;
        logic [1:0]                  ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pc_predictor_btb_table.sv
// Direct-mapped branch target buffer: asynchronous lookup on the fetch pc,
// synchronous counter update / allocation from execute-stage resolution.
module btb_table
    import pc_pkg::*;
#(
    parameter int ADDRESS_WIDTH = PC_ADDRESS_WIDTH,
    parameter int BTB_ENTRIES   = PC_BTB_ENTRIES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] i_lookup_pc,
    output logic                     o_pred_taken,
    output logic [ADDRESS_WIDTH-1:0] o_target,
    input  logic                     i_upd_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_upd_pc,
    input  logic                     i_upd_taken,
    input  logic [ADDRESS_WIDTH-1:0] i_upd_target
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDRESS_WIDTH - IDX_W - 2;

    typedef struct packed {
        logic                     valid;
        logic [TAG_W-1:0]         tag;
        logic [ADDRESS_WIDTH-1:0] target;
        logic [1:0]               ctr;
    } entry_t;

    entry_t r_entry [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lidx;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_ltag;
    logic [TAG_W-1:0] w_utag;
    entry_t           w_lentry;
    entry_t           w_uentry;
    logic             w_lhit;
    logic             w_uhit;
    logic             w_unused_low_bits;

    assign w_lidx   = i_lookup_pc[IDX_W+1:2];
    assign w_ltag   = i_lookup_pc[ADDRESS_WIDTH-1:IDX_W+2];
    assign w_uidx   = i_upd_pc[IDX_W+1:2];
    assign w_utag   = i_upd_pc[ADDRESS_WIDTH-1:IDX_W+2];
    assign w_lentry = r_entry[w_lidx];
    assign w_uentry = r_entry[w_uidx];
    assign w_lhit   = w_lentry.valid && (w_lentry.tag == w_ltag);
    assign w_uhit   = w_uentry.valid && (w_uentry.tag == w_utag);

    // Lookup reads registered contents only, so a same-cycle update is seen
    // one cycle later.
    assign o_pred_taken = w_lhit && w_lentry.ctr[1];
    assign o_target     = w_lentry.target;

    assign w_unused_low_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_entry[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
            end
        end else if (i_upd_valid) begin
            if (w_uhit) begin
                r_entry[w_uidx].ctr <= ctr_next(w_uentry.ctr, i_upd_taken);
                if (i_upd_taken) begin
                    r_entry[w_uidx].target <= i_upd_target;
                end
            end else if (i_upd_taken) begin
                r_entry[w_uidx] <= '{valid: 1'b1, tag: w_utag, target: i_upd_target, ctr: CTR_WEAK_T};
            end
        end
    end

endmodule

// File: rtl/pc_predictor.sv
// Fetch-stage program counter: next-pc priority mux (trigger, redirect,
// stall, BTB prediction, sequential) in front of the BTB.
module pc_predictor
    import pc_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = PC_ADDRESS_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = PC_RESET_VECTOR,
    parameter int                       BTB_ENTRIES   = PC_BTB_ENTRIES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     trigger,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     upd_valid,
    input  logic [ADDRESS_WIDTH-1:0] upd_pc,
    input  logic                     upd_taken,
    input  logic [ADDRESS_WIDTH-1:0] upd_target,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     pred_taken,
    output logic [ADDRESS_WIDTH-1:0] pred_target
);

    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] w_next_pc;
    logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
    logic [ADDRESS_WIDTH-1:0] w_btb_target;
    logic                     w_btb_taken;

    btb_table #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .BTB_ENTRIES   (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_lookup_pc  (r_pc),
        .o_pred_taken (w_btb_taken),
        .o_target     (w_btb_target),
        .i_upd_valid  (upd_valid),
        .i_upd_pc     (upd_pc),
        .i_upd_taken  (upd_taken),
        .i_upd_target (upd_target)
    );

    // Sequential successor wraps modulo 2^ADDRESS_WIDTH.
    assign w_pc_plus4  = r_pc + ADDRESS_WIDTH'(4);
    assign pc          = r_pc;
    assign pred_taken  = w_btb_taken;
    assign pred_target = w_btb_taken ? w_btb_target : w_pc_plus4;

    always_comb begin
        w_next_pc = pred_target;
        if (trigger) begin
            w_next_pc = RESET_VECTOR;
        end else if (redirect) begin
            w_next_pc = redirect_pc;
        end else if (stall) begin
            w_next_pc = r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= w_next_pc;
        end
    end

endmodule
